// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU operation decoder: one-hot op codes,
// RV32 opcode and funct7 values.
package alu_pkg;

  localparam int ALU_OP_W = 13;
  typedef logic [ALU_OP_W-1:0] alu_op_t;

  localparam alu_op_t ALU_OP_ADD  = 13'h0001;
  localparam alu_op_t ALU_OP_SUB  = 13'h0002;
  localparam alu_op_t ALU_OP_XOR  = 13'h0004;
  localparam alu_op_t ALU_OP_OR   = 13'h0008;
  localparam alu_op_t ALU_OP_AND  = 13'h0010;
  localparam alu_op_t ALU_OP_SLL  = 13'h0020;
  localparam alu_op_t ALU_OP_SRL  = 13'h0040;
  localparam alu_op_t ALU_OP_SRA  = 13'h0080;
  localparam alu_op_t ALU_OP_SLT  = 13'h0100;
  localparam alu_op_t ALU_OP_SLTU = 13'h0200;
  localparam alu_op_t ALU_OP_MUL  = 13'h0400;
  localparam alu_op_t ALU_OP_DIV  = 13'h0800;
  localparam alu_op_t ALU_OP_REM  = 13'h1000;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

endpackage

// File: rtl/alu_dec_comb.sv
// Combinational decode of one RV32 OP / OP-IMM word into a one-hot ALU op and
// immediate. Define ALU_DEC_MEXT_EN to decode mul/div/rem.
module alu_dec_comb
  import alu_pkg::*;
(
  input  logic [31:0]         instr,
  output logic [ALU_OP_W-1:0] op,
  output logic [31:0]         imm,
  output logic                use_imm,
  output logic                illegal
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_rd;

  assign opcode    = instr[6:0];
  assign f3        = instr[14:12];
  assign f7        = instr[31:25];
  assign unused_rd = ^instr[11:7];

  // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    op      = '0;
    imm     = '0;
    use_imm = 1'b0;
    case (opcode)
      OPC_OP: begin
        case (f7)
          F7_BASE: begin
            case (f3)
              3'b000:  op = ALU_OP_ADD;
              3'b001:  op = ALU_OP_SLL;
              3'b010:  op = ALU_OP_SLT;
              3'b011:  op = ALU_OP_SLTU;
              3'b100:  op = ALU_OP_XOR;
              3'b101:  op = ALU_OP_SRL;
              3'b110:  op = ALU_OP_OR;
              default: op = ALU_OP_AND;
            endcase
          end
          F7_ALT: begin
            if (f3 == 3'b000)      op = ALU_OP_SUB;
            else if (f3 == 3'b101) op = ALU_OP_SRA;
          end
`ifdef ALU_DEC_MEXT_EN
          F7_MEXT: begin
            case (f3)
              3'b000:  op = ALU_OP_MUL;
              3'b100:  op = ALU_OP_DIV;
              3'b110:  op = ALU_OP_REM;
              default: op = '0;
            endcase
          end
`endif
          default: op = '0;
        endcase
      end
      OPC_OP_IMM: begin
        use_imm = 1'b1;
        imm     = {{20{instr[31]}}, instr[31:20]};
        case (f3)
          3'b000:  op = ALU_OP_ADD;
          3'b010:  op = ALU_OP_SLT;
          3'b011:  op = ALU_OP_SLTU;
          3'b100:  op = ALU_OP_XOR;
          3'b110:  op = ALU_OP_OR;
          3'b111:  op = ALU_OP_AND;
          3'b001: begin
            imm = {27'd0, instr[24:20]};
            if (f7 == F7_BASE) op = ALU_OP_SLL;
          end
          default: begin
            imm = {27'd0, instr[24:20]};
            if (f7 == F7_BASE)     op = ALU_OP_SRL;
            else if (f7 == F7_ALT) op = ALU_OP_SRA;
          end
        endcase
      end
      default: op = '0;
    endcase
    // Legality is defined by whether any op matched; illegal words carry no immediate.
    illegal = (op == '0);
    if (illegal) begin
      imm     = '0;
      use_imm = 1'b0;
    end
  end

endmodule

// File: rtl/alu_op_decoder.sv
// Registered ALU op decoder with a single-entry valid/ready output stage and a
// saturating illegal-word counter. ALU_DEC_MEXT_EN enables M-extension decode.
module alu_op_decoder
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALU_OP_W-1:0] out_op,
  output logic [4:0]          out_rd,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [31:0]         out_imm,
  output logic                out_use_imm,
  output logic                out_illegal,
  output logic [CNT_W-1:0]    err_count
);

  logic [ALU_OP_W-1:0] dec_op;
  logic [31:0]         dec_imm;
  logic                dec_use_imm;
  logic                dec_illegal;
  logic                in_xfer;

  alu_dec_comb u_dec (
    .instr   (in_instr),
    .op      (dec_op),
    .imm     (dec_imm),
    .use_imm (dec_use_imm),
    .illegal (dec_illegal)
  );

  // The stage can take a new word whenever it is empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_op      <= '0;
      out_rd      <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_imm     <= '0;
      out_use_imm <= 1'b0;
      out_illegal <= 1'b0;
      err_count   <= '0;
    end else begin
      if (in_xfer) begin
        out_valid   <= 1'b1;
        out_op      <= dec_op;
        out_rd      <= in_instr[11:7];
        out_rs1     <= in_instr[19:15];
        out_rs2     <= in_instr[24:20];
        out_imm     <= dec_imm;
        out_use_imm <= dec_use_imm;
        out_illegal <= dec_illegal;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (in_xfer && dec_illegal && (err_count != '1)) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_op_decoder.sv
// Self-checking bench for alu_op_decoder: directed encodings, backpressure,
// randomized traffic against a table-driven reference model, saturation, async reset.
module tb_alu_op_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_op;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [31:0] out_imm;
  logic        out_use_imm;
  logic        out_illegal;
  logic [15:0] err_count;

  int total = 0;
  int bad   = 0;

  alu_op_decoder #(.CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op      (out_op),
    .out_rd      (out_rd),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_imm     (out_imm),
    .out_use_imm (out_use_imm),
    .out_illegal (out_illegal),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  // Reference model state: what the output stage should be holding.
  logic        m_valid;
  logic [12:0] m_op;
  logic [4:0]  m_rd, m_rs1, m_rs2;
  logic [31:0] m_imm;
  logic        m_ui, m_ill;
  logic [15:0] m_err;
  logic        ir_seen, ir_exp;

  logic [78:0] got_bus, exp_bus;
  assign got_bus = {out_valid, out_op, out_rd, out_rs1, out_rs2, out_imm, out_use_imm, out_illegal, err_count};
  assign exp_bus = {m_valid, m_op, m_rd, m_rs1, m_rs2, m_imm, m_ui, m_ill, m_err};

  typedef struct packed {
    logic [12:0] op;
    logic [31:0] imm;
    logic        ui;
    logic        ill;
  } dec_s;

  // Op bit index from funct3 lookup tables; -1 means no legal op.
  function automatic dec_s ref_decode(input logic [31:0] w);
    int base_tab[8] = '{0, 5, 8, 9, 2, 6, 3, 4};
    int imm_tab[8]  = '{0, -1, 8, 9, 2, -1, 3, 4};
    int idx = -1;
    logic [6:0] opc = w[6:0];
    logic [2:0] f3  = w[14:12];
    logic [6:0] f7  = w[31:25];
    dec_s d;
    d = '0;
    if (opc == 7'h33) begin
      if (f7 == 7'h00) idx = base_tab[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) idx = 1;
      else if (f7 == 7'h20 && f3 == 3'd5) idx = 7;
`ifdef ALU_DEC_MEXT_EN
      else if (f7 == 7'h01) idx = (f3 == 3'd0) ? 10 : (f3 == 3'd4) ? 11 : (f3 == 3'd6) ? 12 : -1;
`endif
    end else if (opc == 7'h13) begin
      if (f3 == 3'd1)      idx = (f7 == 7'h00) ? 5 : -1;
      else if (f3 == 3'd5) idx = (f7 == 7'h00) ? 6 : (f7 == 7'h20) ? 7 : -1;
      else                 idx = imm_tab[f3];
      d.imm = (f3 == 3'd1 || f3 == 3'd5) ? 32'(w[24:20]) : 32'($signed(w[31:20]));
      d.ui  = 1'b1;
    end
    if (idx < 0) begin
      d.op = '0; d.imm = '0; d.ui = 1'b0; d.ill = 1'b1;
    end else begin
      d.op = 13'(1) << idx; d.ill = 1'b0;
    end
    return d;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    int s = $urandom_range(0, 9);
    int f = $urandom_range(0, 4);
    logic [6:0] opc, f7;
    opc = (s < 4) ? 7'h33 : (s < 8) ? 7'h13 : r[6:0];
    case (f)
      1:       f7 = 7'h20;
      2:       f7 = 7'h01;
      4:       f7 = r[31:25];
      default: f7 = 7'h00;
    endcase
    return {f7, r[24:7], opc};
  endfunction

  task automatic model_reset();
    m_valid = 0; m_op = '0; m_rd = '0; m_rs1 = '0; m_rs2 = '0;
    m_imm = '0; m_ui = 0; m_ill = 0; m_err = '0;
  endtask

  // Drives one cycle from a negedge and advances the model; ends on the next negedge.
  task automatic drive_cycle(input logic v, input logic [31:0] w, input logic rdy);
    dec_s d;
    in_valid = v; in_instr = w; out_ready = rdy;
    #1;
    ir_seen = in_ready;
    ir_exp  = !m_valid || rdy;
    if (v && ir_exp) begin
      d = ref_decode(w);
      m_valid = 1; m_op = d.op; m_imm = d.imm; m_ui = d.ui; m_ill = d.ill;
      m_rd = w[11:7]; m_rs1 = w[19:15]; m_rs2 = w[24:20];
      if (d.ill && m_err != 16'hFFFF) m_err = m_err + 16'd1;
    end else if (rdy) begin
      m_valid = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 0; in_instr = '0; out_ready = 0;
    model_reset();
    #2;
    total++;
    if (got_bus !== exp_bus) begin
      bad++; $display("FAIL reset_state got=%h exp=%h", got_bus, exp_bus);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (got_bus !== exp_bus) begin
      bad++; $display("FAIL post_reset_state got=%h exp=%h", got_bus, exp_bus);
    end
  endtask

  task automatic test_directed();
    logic [15:0] err_before;
    drive_cycle(1, 32'h002081B3, 1);
    total++;
    if ({out_valid, out_op, out_rd, out_rs1, out_rs2, out_use_imm, out_illegal} !==
        {1'b1, 13'd1, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0}) begin
      bad++; $display("FAIL add op=%h rd=%0d rs1=%0d rs2=%0d exp op=1 rd=3 rs1=1 rs2=2", out_op, out_rd, out_rs1, out_rs2);
    end
    drive_cycle(1, 32'h407302B3, 1);
    total++;
    if ({out_op, out_rd, out_rs1, out_rs2} !== {13'd2, 5'd5, 5'd6, 5'd7}) begin
      bad++; $display("FAIL sub op=%h rd=%0d exp op=2 rd=5", out_op, out_rd);
    end
    drive_cycle(1, 32'h40415113, 1);
    total++;
    if ({out_op, out_imm, out_use_imm, out_illegal} !== {13'd128, 32'd4, 1'b1, 1'b0}) begin
      bad++; $display("FAIL srai op=%h imm=%h use_imm=%b exp op=080 imm=4 use_imm=1", out_op, out_imm, out_use_imm);
    end
    drive_cycle(1, 32'hFFF00093, 1);
    total++;
    if ({out_op, out_imm, out_use_imm} !== {13'd1, 32'hFFFFFFFF, 1'b1}) begin
      bad++; $display("FAIL addi op=%h imm=%h exp op=1 imm=ffffffff", out_op, out_imm);
    end
    err_before = err_count;
    drive_cycle(1, 32'h023100B3, 1);
    total++;
`ifdef ALU_DEC_MEXT_EN
    if ({out_op, out_illegal, err_count} !== {13'd1024, 1'b0, err_before}) begin
      bad++; $display("FAIL mul op=%h ill=%b err=%0d exp op=400 ill=0 err=%0d", out_op, out_illegal, err_count, err_before);
    end
`else
    if ({out_op, out_illegal, err_count} !== {13'd0, 1'b1, err_before + 16'd1}) begin
      bad++; $display("FAIL mul op=%h ill=%b err=%0d exp op=0 ill=1 err=%0d", out_op, out_illegal, err_count, err_before + 16'd1);
    end
`endif
    total++;
    if (got_bus !== exp_bus) begin
      bad++; $display("FAIL directed_model got=%h exp=%h", got_bus, exp_bus);
    end
  endtask

  task automatic test_backpressure();
    drive_cycle(0, '0, 1);
    drive_cycle(1, 32'h002081B3, 0);
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1, 32'h407302B3, 0);
      total++;
      if (ir_seen !== 1'b0 || got_bus !== exp_bus || out_rd !== 5'd3 || out_valid !== 1'b1) begin
        bad++; $display("FAIL bp_hold in_ready=%b got=%h exp=%h", ir_seen, got_bus, exp_bus);
      end
    end
    drive_cycle(1, 32'h407302B3, 1);
    total++;
    if (ir_seen !== 1'b1 || out_valid !== 1'b1 || out_rd !== 5'd5 || out_op !== 13'd2) begin
      bad++; $display("FAIL bp_release in_ready=%b valid=%b rd=%0d op=%h exp 1 1 5 002", ir_seen, out_valid, out_rd, out_op);
    end
    drive_cycle(0, '0, 1);
    total++;
    if (out_valid !== 1'b0 || got_bus !== exp_bus) begin
      bad++; $display("FAIL bp_drain got=%h exp=%h", got_bus, exp_bus);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive_cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0);
      total++;
      if (ir_seen !== ir_exp || got_bus !== exp_bus) begin
        bad++; $display("FAIL random_%0d in_ready=%b/%b got=%h exp=%h", i, ir_seen, ir_exp, got_bus, exp_bus);
      end
      if (out_valid && !out_illegal) begin
        total++;
        if (!$onehot(out_op)) begin
          bad++; $display("FAIL onehot_%0d op=%h", i, out_op);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1, rand_instr(), 1);
      total++;
      if (out_valid !== 1'b1 || ir_seen !== 1'b1 || got_bus !== exp_bus) begin
        bad++; $display("FAIL b2b_%0d got=%h exp=%h", i, got_bus, exp_bus);
      end
    end
  endtask

  task automatic test_saturation();
    int n = 65535 - int'(m_err) + 8;
    for (int i = 0; i < n; i++) drive_cycle(1, 32'hFFFFFFFF, 1);
    total++;
    if (err_count !== 16'hFFFF || got_bus !== exp_bus) begin
      bad++; $display("FAIL saturate err=%h exp=ffff got=%h exp=%h", err_count, got_bus, exp_bus);
    end
  endtask

  task automatic test_async_reset();
    drive_cycle(1, 32'h002081B3, 0);
    total++;
    if (out_valid !== 1'b1 || err_count !== 16'hFFFF) begin
      bad++; $display("FAIL pre_async valid=%b err=%h exp 1 ffff", out_valid, err_count);
    end
    #2 rst_n = 0;
    model_reset();
    #1;
    total++;
    if (got_bus !== exp_bus || in_ready !== 1'b1) begin
      bad++; $display("FAIL async_reset got=%h exp=%h in_ready=%b", got_bus, exp_bus, in_ready);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
